// File: rtl/cmd_uart_pkg.sv
// Shared types and constants for the MazeRunner command UART front end.
package cmd_uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 5208;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] NAK     = 8'h5A;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic       {ASM_HI, ASM_LO}                      asm_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop RX synchroniser, mid-bit sampling FSM, byte/ready/framing-error strobes.
module uart_rx_core
    import cmd_uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       start_det
);

    localparam int            CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    logic          meta_q, sync_q, prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            meta_q  <= rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign fall    = prev_q & ~sync_q;
    assign rx_byte = shift_q;

    // Strobes are decoded from registered state so they coincide with the sampling cycle.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_rdy    = 1'b0;
        frm_err   = 1'b0;
        start_det = 1'b0;
        case (state_q)
            RX_IDLE: begin
                baud_d = '0;
                if (fall) begin
                    start_det = 1'b1;
                    state_d   = RX_START;
                end
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_q == FULL_LAST) begin
                    baud_d  = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_q == FULL_LAST) begin
                    baud_d  = '0;
                    state_d = RX_IDLE;
                    rx_rdy  = sync_q;
                    frm_err = ~sync_q;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// MazeRunner serial front end: assembles 2-byte commands from RX and serialises response bytes on TX.
// Build option FRAME_ERR_NAK_EN: automatically transmit NAK (0x5A) on a framing error when TX is idle.
module cmd_uart_wrapper
    import cmd_uart_pkg::*;
#(
    parameter int BAUD_DIV     = DEFAULT_BAUD_DIV,
    parameter int BYTE_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        snd_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frm_err
);

    localparam int            CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
    localparam logic [15:0]   GAP_LIMIT = 16'(BYTE_TIMEOUT);

    logic [7:0] rx_byte;
    logic       rx_rdy, frm_err_w, start_det, nak_req;

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .rx_byte   (rx_byte),
        .rx_rdy    (rx_rdy),
        .frm_err   (frm_err_w),
        .start_det (start_det)
    );

    asm_state_t  asm_q, asm_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] gap_q, gap_d;
    logic        gap_run_q, gap_run_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_baud_q, tx_baud_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          resp_sent_q, resp_sent_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= ASM_HI;
            hi_q        <= '0;
            gap_q       <= '0;
            gap_run_q   <= 1'b0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_baud_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= POS_ACK;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            hi_q        <= hi_d;
            gap_q       <= gap_d;
            gap_run_q   <= gap_run_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // Assembler: clears are applied first so a same-cycle completion overrides them.
    always_comb begin
        asm_d     = asm_q;
        hi_d      = hi_q;
        gap_d     = gap_q;
        gap_run_d = gap_run_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (frm_err_w) begin
            asm_d     = ASM_HI;
            gap_run_d = 1'b0;
        end else begin
            case (asm_q)
                ASM_HI: begin
                    if (start_det) begin
                        cmd_rdy_d = 1'b0;
                    end
                    if (rx_rdy) begin
                        hi_d      = rx_byte;
                        asm_d     = ASM_LO;
                        gap_d     = '0;
                        gap_run_d = 1'b1;
                    end
                end
                ASM_LO: begin
                    if (rx_rdy) begin
                        cmd_d     = {hi_q, rx_byte};
                        cmd_rdy_d = 1'b1;
                        asm_d     = ASM_HI;
                        gap_run_d = 1'b0;
                    end else if (start_det) begin
                        gap_run_d = 1'b0;
                    end else if (gap_run_q) begin
                        if (gap_q >= GAP_LIMIT) begin
                            asm_d     = ASM_HI;
                            gap_run_d = 1'b0;
                        end else if (gap_q != 16'hFFFF) begin
                            gap_d = gap_q + 16'd1;
                        end
                    end
                end
                default: asm_d = ASM_HI;
            endcase
        end
    end

`ifdef FRAME_ERR_NAK_EN
    assign nak_req = frm_err_w & ~snd_resp & (tx_state_q == TX_IDLE);
`else
    assign nak_req = 1'b0;
`endif

    // Transmitter: TX is registered, so the start bit appears the cycle after the request.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (snd_resp || nak_req) begin
                    tx_shift_d  = nak_req ? NAK : resp;
                    tx_state_d  = TX_START;
                    tx_baud_d   = '0;
                    tx_d        = 1'b0;
                    resp_sent_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_baud_q == FULL_LAST) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_baud_q == FULL_LAST) begin
                    tx_baud_d = '0;
                    tx_bit_d  = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_baud_q == FULL_LAST) begin
                    tx_baud_d   = '0;
                    tx_state_d  = TX_IDLE;
                    resp_sent_d = 1'b1;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;
    assign tx_busy   = (tx_state_q != TX_IDLE);
    assign frm_err   = frm_err_w;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Randomised self-checking bench for cmd_uart_wrapper against a byte-stream reference model.
module tb_cmd_uart_wrapper;

    localparam int BD = 16;
    localparam int BT = 400;

    logic        clk = 1'b0;
    logic        rst, rx_line, clr_cmd_rdy, snd_resp;
    logic [7:0]  resp;
    logic        tx_pin, cmd_rdy, resp_sent, tx_busy, frm_err;
    logic [15:0] cmd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cmd_uart_wrapper #(.BAUD_DIV(BD), .BYTE_TIMEOUT(BT)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (rx_line),
        .TX          (tx_pin),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .snd_resp    (snd_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy),
        .frm_err     (frm_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Observed completions and framing-error pulses
    logic [15:0] got_q[$];
    logic        rdy_prev = 1'b0;
    int          frm_cnt  = 0;
    always @(negedge clk) begin
        if (cmd_rdy && !rdy_prev) begin
            got_q.push_back(cmd);
            $display("cmd_rdy rose: cmd=%h", cmd);
        end
        if (frm_err) frm_cnt <= frm_cnt + 1;
        rdy_prev <= cmd_rdy;
    end

    // Reference model: a byte stream, pairing bytes unless the idle gap exceeds the timeout
    logic [15:0] exp_q[$];
    bit          m_hi_v = 1'b0;
    logic [7:0]  m_hi;

    task automatic model_byte(input logic [7:0] b, input int gap);
        if (m_hi_v && gap > BT) m_hi_v = 1'b0;
        if (!m_hi_v) begin
            m_hi   = b;
            m_hi_v = 1'b1;
        end else begin
            exp_q.push_back({m_hi, b});
            m_hi_v = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit clr_in_stop);
        bit seen;
        rx_line = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            tick(BD);
        end
        rx_line = good_stop;
        if (clr_in_stop) begin
            seen        = 1'b0;
            clr_cmd_rdy = 1'b1;
            for (int k = 0; k < BD; k++) begin
                tick(1);
                if (cmd_rdy && !seen) begin
                    seen        = 1'b1;
                    clr_cmd_rdy = 1'b0;
                end
            end
            clr_cmd_rdy = 1'b0;
            chk("set_wins_over_clr", 32'(seen), 32'd1);
        end else begin
            tick(BD);
        end
        rx_line = 1'b1;
    endtask

    task automatic send_model(input logic [7:0] b, input int gap);
        tick(gap);
        model_byte(b, gap);
        send_byte(b, 1'b1, 1'b0);
        $display("rx byte %h sent after gap %0d", b, gap);
    endtask

    task automatic start_tx(input logic [7:0] b);
        resp     = b;
        snd_resp = 1'b1;
        tick(1);
        snd_resp = 1'b0;
    endtask

    // Called at the negedge right after TX dropped for the start bit.
    task automatic tx_frame_check(input logic [7:0] b, input string tag, input bit inject);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        tick(BD / 2);
        chk({tag, "_resp_sent_low"}, 32'(resp_sent), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), {30'd0, tx_busy, tx_pin}, {30'd0, 1'b1, frame[i]});
            if (i == 9) break;
            if (inject && i == 4) begin
                resp     = 8'h00;
                snd_resp = 1'b1;
                tick(1);
                snd_resp = 1'b0;
                tick(BD - 1);
            end else begin
                tick(BD);
            end
        end
        tick(BD / 2 + 1);
        chk({tag, "_done"}, {30'd0, resp_sent, tx_busy}, 32'b10);
        $display("tx frame %h checked (%s)", b, tag);
    endtask

    bit         seen_f, busy_f;
    logic [7:0] rb, hb, lb;
    int         g;

    initial begin
        rst         = 1'b1;
        rx_line     = 1'b1;
        clr_cmd_rdy = 1'b0;
        snd_resp    = 1'b0;
        resp        = 8'h00;
        tick(3);
        chk("rst_tx", 32'(tx_pin), 32'd1);
        rst = 1'b0;
        tick(2);
        chk("rst_outputs", {26'd0, tx_pin, cmd_rdy, resp_sent, tx_busy, frm_err, 1'b0}, 32'b100000);
        chk("rst_cmd", 32'(cmd), 32'd0);

        // Calibrate
        send_model(8'h00, 5);
        send_model(8'h00, 5);
        chk("cal_rdy", 32'(cmd_rdy), 32'd1);
        chk("cal_cmd", 32'(cmd), 32'h0000);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        chk("cal_clr", 32'(cmd_rdy), 32'd0);

        // Heading, with clr asserted in the completion cycle
        send_model(8'h23, 5);
        tick(5);
        model_byte(8'hFF, 5);
        send_byte(8'hFF, 1'b1, 1'b1);
        tick(2);
        chk("head_rdy_stays", 32'(cmd_rdy), 32'd1);
        chk("head_cmd", 32'(cmd), 32'h23FF);

        // Response frame, with an ignored mid-frame request
        start_tx(8'hA5);
        tx_frame_check(8'hA5, "ack", 1'b1);
        for (int r = 0; r < 3; r++) begin
            rb = 8'($urandom_range(0, 255));
            tick($urandom_range(1, 8));
            start_tx(rb);
            tx_frame_check(rb, $sformatf("rnd_tx%0d", r), 1'b0);
        end

        // Byte timeout
        send_model(8'h23, 5);
        send_model(8'h12, BT + 10);
        send_model(8'h34, 3);
        chk("timeout_cmd", 32'(cmd), 32'h1234);
        chk("timeout_rdy", 32'(cmd_rdy), 32'd1);

        // Random byte stream with occasional long gaps
        for (int p = 0; p < 6; p++) begin
            hb = 8'($urandom_range(0, 255));
            lb = 8'($urandom_range(0, 255));
            send_model(hb, $urandom_range(1, 40));
            g = ($urandom_range(0, 3) == 0) ? BT + 20 : $urandom_range(1, 40);
            send_model(lb, g);
        end
        // Re-align the model and DUT on a clean pair boundary
        if (m_hi_v) send_model(8'h5C, BT + 20);
        tick(BT + 20);
        m_hi_v = 1'b0;

        // Full duplex
        model_byte(8'hBE, 0);
        model_byte(8'hEF, 2);
        fork
            begin
                send_byte(8'hBE, 1'b1, 1'b0);
                tick(2);
                send_byte(8'hEF, 1'b1, 1'b0);
            end
            begin
                tick(BD * 3);
                start_tx(8'h3C);
                tx_frame_check(8'h3C, "duplex", 1'b0);
            end
        join
        chk("duplex_cmd", 32'(cmd), 32'hBEEF);

        // Framing error after a good high byte must drop that high byte
        send_model(8'h11, 5);
        tick(5);
        g = frm_cnt;
        fork
            send_byte(8'h99, 1'b0, 1'b0);
            begin
                seen_f = 1'b0;
                for (int k = 0; k < 12 * BD && !seen_f; k++) begin
                    tick(1);
                    if (frm_err) seen_f = 1'b1;
                end
                chk("frm_seen", 32'(seen_f), 32'd1);
`ifdef FRAME_ERR_NAK_EN
                if (seen_f) begin
                    tick(1);
                    tx_frame_check(8'h5A, "nak", 1'b0);
                end
`else
                busy_f = 1'b0;
                for (int k = 0; k < 12 * BD; k++) begin
                    tick(1);
                    if (tx_busy) busy_f = 1'b1;
                end
                chk("no_auto_tx", 32'(busy_f), 32'd0);
`endif
            end
        join
        tick(BD);
        chk("frm_once", 32'(frm_cnt - g), 32'd1);
        m_hi_v = 1'b0;
        send_model(8'h45, 5);
        send_model(8'h67, 5);
        chk("post_frm_cmd", 32'(cmd), 32'h4567);

        // Reset during bit 4 of a TX frame
        start_tx(8'hC3);
        tick(5 * BD + BD / 2);
        rst     = 1'b1;
        rx_line = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_tx", {29'd0, tx_pin, tx_busy, resp_sent}, 32'b100);

        // Reset during the low byte
        send_model(8'h77, 5);
        tick(5);
        rx_line = 1'b0;
        tick(BD);
        for (int i = 0; i < 3; i++) begin
            rx_line = 1'b1;
            tick(BD);
        end
        rst     = 1'b1;
        rx_line = 1'b1;
        tick(1);
        rst = 1'b0;
        m_hi_v = 1'b0;
        chk("rst_mid_lo", {15'd0, cmd_rdy, cmd}, 32'd0);
        send_model(8'h23, 2 * BD);
        send_model(8'hFF, 5);
        chk("post_rst_cmd", 32'(cmd), 32'h23FF);
        chk("post_rst_rdy", 32'(cmd_rdy), 32'd1);

        // Whole completion history against the model
        tick(BD);
        chk("cmd_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("cmd_hist%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
